// File: rtl/led_device.sv
// Four-LED write-side bus peripheral with per-LED 8-bit PWM and prescaled blink gating.
// Optional LED_DEVICE_READBACK_EN adds a tri-stated data_out register readback port.
module led_device #(
  parameter int unsigned PRESCALE_W = 8,
  parameter int unsigned PWM_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] address,
  input  logic       enable,
  input  logic       mode,
  input  logic [7:0] data_in,
  output logic [3:0] led_out
`ifdef LED_DEVICE_READBACK_EN
  ,
  output logic [7:0] data_out
`endif
);

  typedef enum logic [0:0] {
    StOff = 1'b0,
    StOn  = 1'b1
  } blink_st_e;

  // Register file
  logic [3:0][PWM_W-1:0] duty_q, duty_d;
  logic [3:0]            mask_q, mask_d;
  logic [7:0]            period_q, period_d;
  logic                  ctrl_q, ctrl_d;

  // Free-running timing state
  logic [PWM_W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [7:0]            blink_cnt_q, blink_cnt_d;
  blink_st_e             blink_st_q, blink_st_d;

  logic [3:0]            led_q, led_d;
  logic [3:0]            raw;
  logic                  wr_en;
  logic                  wr_period;
  logic                  tick;
  logic                  blink_phase;

  assign wr_en     = enable & ~mode;
  assign wr_period = wr_en & (address == 4'h5);
  assign tick      = (presc_q == {PRESCALE_W{1'b1}});

  // Bus write decode; 0x7-0xF fall through with no side effect.
  always_comb begin
    duty_d   = duty_q;
    mask_d   = mask_q;
    period_d = period_q;
    ctrl_d   = ctrl_q;
    if (wr_en) begin
      case (address)
        4'h0, 4'h1, 4'h2, 4'h3: duty_d[address[1:0]] = data_in[PWM_W-1:0];
        4'h4:                   mask_d   = data_in[3:0];
        4'h5:                   period_d = data_in;
        4'h6:                   ctrl_d   = data_in[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    presc_d   = wr_period ? '0 : presc_q + 1'b1;
  end

  // Blink FSM next state: a period write restarts the ON phase and beats any tick.
  always_comb begin
    blink_st_d  = blink_st_q;
    blink_cnt_d = blink_cnt_q;
    if (wr_period || (period_q == 8'd0)) begin
      blink_st_d  = StOn;
      blink_cnt_d = 8'd0;
    end else if (tick) begin
      if (blink_cnt_q == period_q - 8'd1) begin
        blink_cnt_d = 8'd0;
        blink_st_d  = (blink_st_q == StOn) ? StOff : StOn;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Blink FSM output
  always_comb begin
    blink_phase = (blink_st_q == StOn);
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      raw[i]   = (pwm_cnt_q < duty_q[i]);
      led_d[i] = ctrl_q & raw[i] & (~mask_q[i] | blink_phase);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      duty_q      <= '0;
      mask_q      <= '0;
      period_q    <= '0;
      ctrl_q      <= 1'b0;
      pwm_cnt_q   <= '0;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_st_q  <= StOn;
      led_q       <= '0;
    end else begin
      duty_q      <= duty_d;
      mask_q      <= mask_d;
      period_q    <= period_d;
      ctrl_q      <= ctrl_d;
      pwm_cnt_q   <= pwm_cnt_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_st_q  <= blink_st_d;
      led_q       <= led_d;
    end
  end

  assign led_out = led_q;

`ifdef LED_DEVICE_READBACK_EN
  logic [7:0] rd_q, rd_d;

  // Capture reflects register contents just before the read edge.
  always_comb begin
    rd_d = rd_q;
    if (enable && mode) begin
      case (address)
        4'h0, 4'h1, 4'h2, 4'h3: rd_d = 8'(duty_q[address[1:0]]);
        4'h4:                   rd_d = {4'b0, mask_q};
        4'h5:                   rd_d = period_q;
        4'h6:                   rd_d = {7'b0, ctrl_q};
        4'h7:                   rd_d = {3'b0, blink_phase, led_q};
        default:                rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= 8'h00;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign data_out = (enable && mode) ? rd_q : 8'bz;
`endif

endmodule
